// File: rtl/temporal_pkg.sv
// Shared types for the temporal (race-logic) encoder and downstream gamma-cycle stages.
package temporal_pkg;

    // Widest edge-time field a slot can carry; supports gamma cycles up to 256 clocks.
    localparam int unsigned SlotValW = 8;

    typedef enum logic [1:0] {
        ENC_IDLE,
        ENC_WAIT,
        ENC_FIRE,
        ENC_DONE
    } enc_state_t;

    typedef struct packed {
        logic                valid;
        logic                inf;
        logic [SlotValW-1:0] value;
    } slot_t;

endpackage

// File: rtl/temporal_encoder_if.sv
// Valid/ready input channel carrying one edge time (or infinity) per transfer.
interface temporal_encoder_if #(
    parameter int unsigned GAMMA_CYCLE_WIDTH = 16
);
    localparam int unsigned ValW = $clog2(GAMMA_CYCLE_WIDTH);

    logic            in_valid;
    logic            in_ready;
    logic [ValW-1:0] in_value;
    logic            in_inf;

    modport master (
        output in_valid,
        output in_value,
        output in_inf,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_value,
        input  in_inf,
        output in_ready
    );

endinterface

// File: rtl/gamma_counter.sv
// Free-running gamma-cycle counter with a registered start flag; reusable by decode stages.
module gamma_counter #(
    parameter  int unsigned GAMMA_CYCLE_WIDTH = 16,
    localparam int unsigned ValW              = $clog2(GAMMA_CYCLE_WIDTH)
) (
    input  logic            clk,
    input  logic            rst,
    output logic [ValW-1:0] cnt_o,
    output logic [ValW-1:0] cnt_next_o,
    output logic            start_o,
    output logic            last_o
);

    logic [ValW-1:0] cnt_q, cnt_d;
    logic            start_q;

    // Power-of-two period: natural overflow is the wrap.
    assign cnt_d = cnt_q + ValW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            start_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            start_q <= (cnt_d == '0);
        end
    end

    assign cnt_o      = cnt_q;
    assign cnt_next_o = cnt_d;
    assign start_o    = start_q;
    assign last_o     = &cnt_q;

endmodule

// File: rtl/temporal_encoder.sv
// Binary-to-temporal encoder: one rising edge per gamma cycle at the accepted edge time.
// Define TEMPORAL_PULSE_MODE_EN for fixed-length pulses instead of level-held edges.
module temporal_encoder
    import temporal_pkg::*;
#(
    parameter  int unsigned GAMMA_CYCLE_WIDTH = 16,
    parameter  int unsigned PULSE_WIDTH       = 8,
    localparam int unsigned ValW              = $clog2(GAMMA_CYCLE_WIDTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    temporal_encoder_if.slave        in_if,
    output logic [ValW-1:0]          gamma_cnt,
    output logic                     gamma_start,
    output logic                     out
);

    if (GAMMA_CYCLE_WIDTH < 4 || (GAMMA_CYCLE_WIDTH & (GAMMA_CYCLE_WIDTH - 1)) != 0) begin : g_chk_gw
        $error("GAMMA_CYCLE_WIDTH must be a power of two >= 4");
    end
    if (PULSE_WIDTH < 1 || PULSE_WIDTH > GAMMA_CYCLE_WIDTH) begin : g_chk_pw
        $error("PULSE_WIDTH must be in 1..GAMMA_CYCLE_WIDTH");
    end
    if (ValW > SlotValW) begin : g_chk_slot
        $error("GAMMA_CYCLE_WIDTH too large for slot value field");
    end

    logic [ValW-1:0]     cnt_next;
    logic                cnt_last;
    logic [SlotValW-1:0] cnt_next_ext;

    gamma_counter #(
        .GAMMA_CYCLE_WIDTH(GAMMA_CYCLE_WIDTH)
    ) u_gamma_counter (
        .clk       (clk),
        .rst       (rst),
        .cnt_o     (gamma_cnt),
        .cnt_next_o(cnt_next),
        .start_o   (gamma_start),
        .last_o    (cnt_last)
    );

    assign cnt_next_ext = SlotValW'(cnt_next);

    // Slot handling

    slot_t pend_q, pend_d;
    slot_t act_q, act_d;
    slot_t in_slot;
    logic  hs;

    assign in_if.in_ready = ~pend_q.valid;
    assign hs             = in_if.in_valid & ~pend_q.valid;

    always_comb begin
        in_slot       = '0;
        in_slot.valid = 1'b1;
        in_slot.inf   = in_if.in_inf;
        in_slot.value = SlotValW'(in_if.in_value);
    end

    always_comb begin
        pend_d = pend_q;
        act_d  = act_q;
        if (cnt_last) begin
            // A boundary handshake only happens with pending empty, so it bypasses straight in.
            if (pend_q.valid) begin
                act_d = pend_q;
            end else if (hs) begin
                act_d = in_slot;
            end else begin
                act_d = '0;
            end
            pend_d = '0;
        end else if (hs) begin
            pend_d = in_slot;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
            act_q  <= '0;
        end else begin
            pend_q <= pend_d;
            act_q  <= act_d;
        end
    end

    // Output FSM: evaluated on next count/active so out lines up with gamma_cnt.

    enc_state_t state_q;
    logic       out_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ENC_IDLE;
            out_q   <= 1'b0;
        end else if (cnt_next == '0) begin
            if (!act_d.valid || act_d.inf) begin
                state_q <= ENC_IDLE;
                out_q   <= 1'b0;
            end else if (act_d.value == '0) begin
                state_q <= ENC_FIRE;
                out_q   <= 1'b1;
            end else begin
                state_q <= ENC_WAIT;
                out_q   <= 1'b0;
            end
        end else begin
            unique case (state_q)
                ENC_WAIT: begin
                    if (cnt_next_ext >= act_d.value) begin
                        state_q <= ENC_FIRE;
                        out_q   <= 1'b1;
                    end
                end
                ENC_FIRE: begin
`ifdef TEMPORAL_PULSE_MODE_EN
                    // Clipping at the boundary falls out of the wrap re-entry above.
                    if (32'(cnt_next_ext) - 32'(act_d.value) >= PULSE_WIDTH) begin
                        state_q <= ENC_DONE;
                        out_q   <= 1'b0;
                    end
`endif
                end
                default: begin
                end
            endcase
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_temporal_encoder.sv
// Directed bench for temporal_encoder (GAMMA_CYCLE_WIDTH=16, PULSE_WIDTH=8).
module tb_temporal_encoder;

    localparam int unsigned Gw = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] gamma_cnt;
    logic       gamma_start;
    logic       out;
    int         n_total = 0;
    int         n_bad   = 0;

    temporal_encoder_if #(.GAMMA_CYCLE_WIDTH(Gw)) in_if ();

    temporal_encoder #(
        .GAMMA_CYCLE_WIDTH(Gw),
        .PULSE_WIDTH      (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_if      (in_if),
        .gamma_cnt  (gamma_cnt),
        .gamma_start(gamma_start),
        .out        (out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected out pattern for one gamma cycle, bit i = gamma_cnt i.
    function automatic logic [15:0] mask_for(input int v, input bit inf);
        logic [15:0] m;
        if (inf) return 16'h0000;
`ifdef TEMPORAL_PULSE_MODE_EN
        m = 16'h00FF << v;
`else
        m = 16'hFFFF << v;
`endif
        return m;
    endfunction

    task automatic wait_cnt(input int v);
        int n = 0;
        while (gamma_cnt !== 4'(v) && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) check_eq("wait_cnt timeout", 32'(gamma_cnt), 32'(v));
    endtask

    task automatic send(input int v, input bit inf);
        int n = 0;
        while (in_if.in_ready !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) check_eq("send timeout", 32'(in_if.in_ready), 32'd1);
        in_if.in_valid = 1'b1;
        in_if.in_value = 4'(v);
        in_if.in_inf   = inf;
        @(negedge clk);
        in_if.in_valid = 1'b0;
        in_if.in_inf   = 1'b0;
    endtask

    task automatic observe(input logic [15:0] mask, input string tag);
        wait_cnt(0);
        for (int i = 0; i < 16; i++) begin
            check_eq($sformatf("%s cnt@%0d", tag, i), 32'(gamma_cnt), 32'(i));
            check_eq($sformatf("%s start@%0d", tag, i), 32'(gamma_start), 32'(i == 0));
            check_eq($sformatf("%s out@%0d", tag, i), 32'(out), 32'(mask[i]));
            @(negedge clk);
        end
    endtask

    initial begin
        in_if.in_valid = 1'b0;
        in_if.in_value = '0;
        in_if.in_inf   = 1'b0;

        // Reset state
        #1 rst = 1'b1;
        #2;
        check_eq("rst cnt", 32'(gamma_cnt), 32'd0);
        check_eq("rst start", 32'(gamma_start), 32'd1);
        check_eq("rst out", 32'(out), 32'd0);
        check_eq("rst ready", 32'(in_if.in_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("release cnt", 32'(gamma_cnt), 32'd1);
        check_eq("release out", 32'(out), 32'd0);

        // Value 5 handshaked mid-cycle
        wait_cnt(3);
        check_eq("A ready", 32'(in_if.in_ready), 32'd1);
        in_if.in_valid = 1'b1;
        in_if.in_value = 4'd5;
        @(negedge clk);
        in_if.in_valid = 1'b0;
        check_eq("A pending full", 32'(in_if.in_ready), 32'd0);
        check_eq("A out still 0", 32'(out), 32'd0);
        observe(mask_for(5, 0), "v5");

        // Back-to-back 0, 15, inf, then 15 -> 0 carry through the boundary
        fork send(0, 0); observe(16'h0000, "idle"); join
        fork send(15, 0); observe(mask_for(0, 0), "v0"); join
        fork send(0, 1); observe(mask_for(15, 0), "v15"); join
        fork send(15, 0); observe(mask_for(0, 1), "inf"); join
        fork send(0, 0); observe(mask_for(15, 0), "v15b"); join
        observe(mask_for(0, 0), "v0b");
        observe(16'h0000, "empty");

        // Pending full with in_valid held: nothing more accepted
        in_if.in_valid = 1'b1;
        in_if.in_value = 4'd7;
        @(negedge clk);
        check_eq("C full", 32'(in_if.in_ready), 32'd0);
        in_if.in_value = 4'd3;
        wait_cnt(15);
        check_eq("C full at boundary", 32'(in_if.in_ready), 32'd0);
        @(negedge clk);
        check_eq("C drained", 32'(in_if.in_ready), 32'd1);
        in_if.in_valid = 1'b0;
        observe(mask_for(7, 0), "v7");
        observe(16'h0000, "no late accept");

        // Handshake in the boundary cycle bypasses pending
        wait_cnt(15);
        check_eq("C2 ready", 32'(in_if.in_ready), 32'd1);
        in_if.in_valid = 1'b1;
        in_if.in_value = 4'd9;
        @(negedge clk);
        in_if.in_valid = 1'b0;
        check_eq("C2 pending empty", 32'(in_if.in_ready), 32'd1);
        observe(mask_for(9, 0), "v9 boundary");

        // Reset mid-cycle with out high and a pending value
        send(2, 0);
        wait_cnt(0);
        send(4, 0);
        wait_cnt(9);
        check_eq("D pre out", 32'(out), 32'd1);
        check_eq("D pre ready", 32'(in_if.in_ready), 32'd0);
        #2 rst = 1'b1;
        #1;
        check_eq("D rst out", 32'(out), 32'd0);
        check_eq("D rst cnt", 32'(gamma_cnt), 32'd0);
        check_eq("D rst start", 32'(gamma_start), 32'd1);
        check_eq("D rst ready", 32'(in_if.in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        observe(16'h0000, "post rst a");
        observe(16'h0000, "post rst b");
        fork send(11, 0); observe(16'h0000, "post rst c"); join
        observe(mask_for(11, 0), "v11 after rst");

`ifdef TEMPORAL_PULSE_MODE_EN
        fork send(4, 0); observe(16'h0000, "pulse idle"); join
        fork send(12, 0); observe(16'h0FF0, "pulse v4"); join
        observe(16'hF000, "pulse v12 clipped");
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
